// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared definitions for the serializer transmit block: the FSM state
// encoding, the default level driven on the serial line between words,
// and a helper that sizes the bit counter.
// Optional feature macro used by this block: SERIALIZER_PARITY_EN.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..width-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serializer_shift_reg.sv
// serializer_shift_reg
// Parallel-load shift register feeding the serializer output flop.
// The load consumes the first bit of the word (the top level sends that bit
// straight from the parallel input), so after a load the end bit already
// holds the second bit to transmit and every shift exposes the next one.
// Ports:
//   clock_in    rising-edge clock
//   reset_n     asynchronous active-low reset, clears the register
//   load        parallel load of load_data (takes priority over shift_en)
//   shift_en    advance one bit toward the output end
//   load_data   parallel word
//   serial_out  end bit of the register (MSB or LSB depending on MSB_FIRST)
module serializer_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr_q;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= shift1(load_data);
    end else if (shift_en) begin
      sr_q <= shift1(sr_q);
    end
  end

  assign serial_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serializer.sv
// serializer
// Parallel-to-serial transmitter. Accepts WIDTH-bit words on a valid/ready
// handshake and emits them one bit per clock on Data_out, with frame_sync
// marking the first bit of each word. Words stream back to back with no
// idle gap while data_valid stays high.
// Optional feature: define SERIALIZER_PARITY_EN to append an even parity
// bit after each word (word period WIDTH+1 instead of WIDTH).
// Ports:
//   clock_in    rising-edge clock
//   reset_n     asynchronous active-low reset
//   Data_in     parallel word, sampled on the accept edge
//   data_valid  upstream has a word available
//   data_ready  combinational; a word is taken at this edge if valid
//   Data_out    registered serial bit (IDLE_LEVEL between words)
//   frame_sync  registered; high during the first bit of each word
//   busy        registered; high while a word bit is on Data_out
module serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             Data_out,
  output logic             frame_sync,
  output logic             busy
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_out_d, frame_sync_d, busy_d;
  logic             load, shift_en, sr_out, accept, first_bit;

  assign first_bit = MSB_FIRST ? Data_in[WIDTH-1] : Data_in[0];

  serializer_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .load       (load),
    .shift_en   (shift_en),
    .load_data  (Data_in),
    .serial_out (sr_out)
  );

`ifdef SERIALIZER_PARITY_EN
  logic parity_q;

  // With parity the last data bit is not the end of the word, so the
  // handshake only opens in the parity cycle; accepting earlier would
  // collide with the parity bit.
  assign data_ready = (state_q == IDLE) || (state_q == PARITY);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^Data_in;
    end
  end
`else
  assign data_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
`endif

  assign accept = data_valid && data_ready;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      Data_out   <= IDLE_LEVEL;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      Data_out   <= data_out_d;
      frame_sync <= frame_sync_d;
      busy       <= busy_d;
    end
  end

  // An accept can only occur at a word boundary (idle, last cycle of a
  // word), and always starts the next word there; otherwise the FSM
  // advances the current word or falls back to idle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = Data_out;
    frame_sync_d = 1'b0;
    busy_d       = busy;
    load         = 1'b0;
    shift_en     = 1'b0;

    if (accept) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      load         = 1'b1;
      data_out_d   = first_bit;
      frame_sync_d = 1'b1;
      busy_d       = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST) begin
            cnt_d      = cnt_q + 1'b1;
            shift_en   = 1'b1;
            data_out_d = sr_out;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d    = PARITY;
            data_out_d = parity_q;
`else
            state_d    = IDLE;
            cnt_d      = '0;
            data_out_d = IDLE_LEVEL;
            busy_d     = 1'b0;
`endif
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          data_out_d = IDLE_LEVEL;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer
// Directed bench for serializer: an MSB-first instance and an LSB-first
// instance share clock and reset. Expected bit sequences and parity bits
// are hand-derived constants from the transmitted words.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PERIOD = 9;
`else
  localparam int PERIOD = 8;
`endif

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] data_in_m = '0, data_in_l = '0;
  logic       valid_m = 1'b0, valid_l = 1'b0;
  logic       ready_m, ready_l, dout_m, dout_l, fs_m, fs_l, busy_m, busy_l;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock_in = ~clock_in;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .Data_in    (data_in_m),
    .data_valid (valid_m),
    .data_ready (ready_m),
    .Data_out   (dout_m),
    .frame_sync (fs_m),
    .busy       (busy_m)
  );

  serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .Data_in    (data_in_l),
    .data_valid (valid_l),
    .data_ready (ready_l),
    .Data_out   (dout_l),
    .frame_sync (fs_l),
    .busy       (busy_l)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  // Called at the negedge inside bit 0 of word w. Drives the next upstream
  // word at that point (ready is low mid-word, so it must not be taken
  // early) and returns at the negedge just after the word's last cycle.
  task automatic applyStimulus(input bit lsb, input logic [7:0] w, input logic par,
                               input logic [7:0] next_word, input logic next_valid);
    logic exp_bit;
    for (int i = 0; i < PERIOD; i++) begin
      if (i < 8) exp_bit = lsb ? w[i] : w[7-i];
      else       exp_bit = par;
      checkOutput($sformatf("%s_bit%0d_%h", lsb ? "lsb" : "msb", i, w),
                  lsb ? dout_l : dout_m, exp_bit);
      checkOutput($sformatf("fs%0d_%h", i, w), lsb ? fs_l : fs_m, (i == 0));
      checkOutput($sformatf("busy%0d_%h", i, w), lsb ? busy_l : busy_m, 1'b1);
      checkOutput($sformatf("ready%0d_%h", i, w), lsb ? ready_l : ready_m, (i == PERIOD-1));
      if (i == 0) begin
        if (lsb) begin data_in_l = next_word; valid_l = next_valid; end
        else     begin data_in_m = next_word; valid_m = next_valid; end
      end
      nextCycle();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_dout"}, dout_m, 1'b1);
    checkOutput({tag, "_busy"}, busy_m, 1'b0);
    checkOutput({tag, "_fs"},   fs_m,   1'b0);
    checkOutput({tag, "_ready"}, ready_m, 1'b1);
  endtask

  initial begin
    // Reset with valid asserted: nothing may be taken.
    valid_m   = 1'b1;
    data_in_m = 8'hFF;
    repeat (3) @(negedge clock_in);
    checkIdle("reset");
    checkOutput("reset_lsb_dout", dout_l, 1'b1);
    reset_n = 1'b1;
    valid_m = 1'b0;
    nextCycle();
    checkIdle("post_reset");

    // Single word, one-cycle valid pulse.
    data_in_m = 8'hA5;
    valid_m   = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0);
    checkIdle("after_a5");
    nextCycle();
    checkIdle("after_a5_2");

    // Back-to-back stream with valid held: A5, 3C, 55, 07.
    data_in_m = 8'hA5;
    valid_m   = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 8'hA5, 1'b0, 8'h3C, 1'b1);
    applyStimulus(1'b0, 8'h3C, 1'b0, 8'h55, 1'b1);
    applyStimulus(1'b0, 8'h55, 1'b0, 8'h07, 1'b1);
    applyStimulus(1'b0, 8'h07, 1'b1, 8'h00, 1'b0);
    checkIdle("after_stream");

    // LSB-first instance.
    data_in_l = 8'h01;
    valid_l   = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h01, 1'b0);
    checkOutput("lsb_idle_dout", dout_l, 1'b1);
    checkOutput("lsb_idle_busy", busy_l, 1'b0);

    // Reset in the middle of 8'hFF at bit 3.
    data_in_m = 8'hFF;
    valid_m   = 1'b1;
    nextCycle();
    valid_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ff_bit%0d", i), dout_m, 1'b1);
      checkOutput($sformatf("ff_busy%0d", i), busy_m, 1'b1);
      nextCycle();
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_dout", dout_m, 1'b1);
    checkOutput("midrst_busy", busy_m, 1'b0);
    checkOutput("midrst_fs",   fs_m,   1'b0);
    @(negedge clock_in);
    reset_n   = 1'b1;
    data_in_m = 8'h00;
    valid_m   = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkIdle("after_00");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
